// File: rtl/memtest_prbs_pkg.sv
// Shared definitions for the PRBS memory tester: polynomial mode encodings,
// tap positions per polynomial and the seed lockup guard.
package memtest_prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS23 = 2'd2,
    MODE_PRBS31 = 2'd3
  } mode_e;

  localparam logic [4:0] TAP_A_PRBS7  = 5'd6;
  localparam logic [4:0] TAP_B_PRBS7  = 5'd5;
  localparam logic [4:0] TAP_A_PRBS15 = 5'd14;
  localparam logic [4:0] TAP_B_PRBS15 = 5'd13;
  localparam logic [4:0] TAP_A_PRBS23 = 5'd22;
  localparam logic [4:0] TAP_B_PRBS23 = 5'd17;
  localparam logic [4:0] TAP_A_PRBS31 = 5'd30;
  localparam logic [4:0] TAP_B_PRBS31 = 5'd27;

  function automatic logic [4:0] tap_a(input mode_e m);
    case (m)
      MODE_PRBS7:  tap_a = TAP_A_PRBS7;
      MODE_PRBS15: tap_a = TAP_A_PRBS15;
      MODE_PRBS23: tap_a = TAP_A_PRBS23;
      default:     tap_a = TAP_A_PRBS31;
    endcase
  endfunction

  function automatic logic [4:0] tap_b(input mode_e m);
    case (m)
      MODE_PRBS7:  tap_b = TAP_B_PRBS7;
      MODE_PRBS15: tap_b = TAP_B_PRBS15;
      MODE_PRBS23: tap_b = TAP_B_PRBS23;
      default:     tap_b = TAP_B_PRBS31;
    endcase
  endfunction

  // XNOR feedback locks up when every active bit is one; such a seed is
  // replaced by zero, which walks the normal sequence from its start.
  function automatic logic [30:0] guard_seed(input logic [30:0] seed, input mode_e m);
    logic [30:0] mask;
    logic [4:0]  ta;
    ta   = tap_a(m);
    mask = 31'd0;
    for (int i = 0; i < 31; i++) begin
      if (i <= int'(ta)) mask[i] = 1'b1;
    end
    guard_seed = ((seed & mask) == mask) ? 31'd0 : seed;
  endfunction

endpackage

// File: rtl/memtest_prbs_lfsr.sv
// 31-bit XNOR LFSR that produces WIDTH consecutive output bits per cycle.
// The word reflects the current state; the state moves past it on adv.
module memtest_prbs_lfsr
  import memtest_prbs_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [30:0]      seed,
  input  logic             load,
  input  logic             adv,
  output logic [WIDTH-1:0] word
);

  logic [30:0] state_q;
  logic [30:0] state_d;
  logic [30:0] walk_s;
  logic [4:0]  ta_s;
  logic [4:0]  tb_s;
  logic        bit_s;

  // Unroll WIDTH steps of the LFSR and pick the next state (load wins over adv).
  always_comb begin
    ta_s   = tap_a(mode_e'(mode));
    tb_s   = tap_b(mode_e'(mode));
    walk_s = state_q;
    word   = '0;
    bit_s  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_s   = ~(walk_s[ta_s] ^ walk_s[tb_s]);
      word[i] = bit_s;
      walk_s  = {walk_s[29:0], bit_s};
    end
    if (load) begin
      state_d = guard_seed(seed, mode_e'(mode));
    end else if (adv) begin
      state_d = walk_s;
    end else begin
      state_d = state_q;
    end
  end

  // State register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= 31'd0;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/memtest_prbs.sv
// PRBS memory tester: a generator LFSR feeding a valid/ready word output and an
// independent checker LFSR comparing read-back data, with counters and sticky err.
module memtest_prbs
  import memtest_prbs_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [30:0]      seed,
  input  logic             load,
  input  logic             gen_en,
  output logic [WIDTH-1:0] rand_word,
  output logic             rand_valid,
  input  logic             rand_ready,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_data,
  output logic [31:0]      gen_count,
  output logic [31:0]      err_count,
  output logic             err
);

  logic [WIDTH-1:0] gen_word_s;
  logic [WIDTH-1:0] chk_word_s;
  logic             gen_adv_s;
  logic             mismatch_s;

  logic [WIDTH-1:0] rand_q, rand_d;
  logic             rand_valid_q, rand_valid_d;
  logic [31:0]      gen_count_q, gen_count_d;
  logic [31:0]      err_count_q, err_count_d;
  logic             err_q, err_d;

  assign gen_adv_s  = gen_en && (!rand_valid_q || rand_ready);
  assign mismatch_s = chk_valid && (chk_data != chk_word_s);

  memtest_prbs_lfsr #(.WIDTH(WIDTH)) u_gen (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .seed (seed),
    .load (load),
    .adv  (gen_adv_s),
    .word (gen_word_s)
  );

  memtest_prbs_lfsr #(.WIDTH(WIDTH)) u_chk (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .seed (seed),
    .load (load),
    .adv  (chk_valid),
    .word (chk_word_s)
  );

  // Output word handshake and production counter.
  always_comb begin
    rand_d       = rand_q;
    rand_valid_d = rand_valid_q;
    gen_count_d  = gen_count_q;
    if (load) begin
      rand_d       = '0;
      rand_valid_d = 1'b0;
      gen_count_d  = 32'd0;
    end else if (gen_adv_s) begin
      rand_d       = gen_word_s;
      rand_valid_d = 1'b1;
      gen_count_d  = gen_count_q + 32'd1;
    end else if (rand_valid_q && rand_ready) begin
      rand_valid_d = 1'b0;
    end else begin
      rand_valid_d = rand_valid_q;
    end
  end

  // Mismatch accounting: saturating error count and sticky flag.
  always_comb begin
    err_count_d = err_count_q;
    err_d       = err_q;
    if (load) begin
      err_count_d = 32'd0;
      err_d       = 1'b0;
    end else if (mismatch_s) begin
      err_d = 1'b1;
      if (err_count_q != 32'hFFFF_FFFF) err_count_d = err_count_q + 32'd1;
      else                              err_count_d = err_count_q;
    end else begin
      err_d = err_q;
    end
  end

  // Registered outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rand_q       <= '0;
      rand_valid_q <= 1'b0;
      gen_count_q  <= 32'd0;
      err_count_q  <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      rand_q       <= rand_d;
      rand_valid_q <= rand_valid_d;
      gen_count_q  <= gen_count_d;
      err_count_q  <= err_count_d;
      err_q        <= err_d;
    end
  end

  assign rand_word  = rand_q;
  assign rand_valid = rand_valid_q;
  assign gen_count  = gen_count_q;
  assign err_count  = err_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_memtest_prbs.sv
// Self-checking bench for memtest_prbs (WIDTH=64): handshake vector table plus
// directed sequences for backpressure, loopback checking, load and saturation.
module tb_memtest_prbs;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'd3;
  logic [30:0]   seed = 31'd0;
  logic          load = 1'b0;
  logic          gen_en = 1'b0;
  logic [W-1:0]  rand_word;
  logic          rand_valid;
  logic          rand_ready = 1'b0;
  logic          chk_valid = 1'b0;
  logic [W-1:0]  chk_data = '0;
  logic [31:0]   gen_count;
  logic [31:0]   err_count;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memtest_prbs #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .seed       (seed),
    .load       (load),
    .gen_en     (gen_en),
    .rand_word  (rand_word),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .chk_valid  (chk_valid),
    .chk_data   (chk_data),
    .gen_count  (gen_count),
    .err_count  (err_count),
    .err        (err)
  );

  typedef struct {
    logic        gen_en;
    logic        rand_ready;
    logic        exp_valid;
    logic [31:0] exp_count;
  } vec_t;

  vec_t        vecs [10];
  logic [63:0] w3 [0:16];
  logic [30:0] ms;

  // Golden model: 64 bit-serial steps of the XNOR LFSR from state si.
  function automatic logic [63:0] mword(input logic [1:0] m, input logic [30:0] si,
                                        output logic [30:0] so);
    int ta, tb;
    logic [30:0] s;
    logic o;
    logic [63:0] w;
    case (m)
      2'd0:    begin ta = 6;  tb = 5;  end
      2'd1:    begin ta = 14; tb = 13; end
      2'd2:    begin ta = 22; tb = 17; end
      default: begin ta = 30; tb = 27; end
    endcase
    s = si;
    w = 64'd0;
    for (int i = 0; i < 64; i++) begin
      o = ~(s[ta] ^ s[tb]);
      w[i] = o;
      s = {s[29:0], o};
    end
    so = s;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; gen_en = 1'b0; rand_ready = 1'b0; chk_valid = 1'b0; load = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  logic [191:0] stream;
  logic [63:0]  held;
  logic [63:0]  exp_first;
  logic [30:0]  tmp_s;
  int           period_bad;

  initial begin
    // Golden words from the all-zero state, PRBS31.
    ms = 31'd0;
    w3[0] = 64'd0;
    for (int k = 1; k <= 16; k++) w3[k] = mword(2'd3, ms, ms);

    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'd1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'd2};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'd2};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'd3};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'd4};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 32'd4};

    // Reset state.
    mode = 2'd3;
    do_reset();
    check("reset_rand", rand_word, 64'd0);
    check("reset_valid", {63'd0, rand_valid}, 64'd0);
    check("reset_gen_count", {32'd0, gen_count}, 64'd0);
    check("reset_err_count", {32'd0, err_count}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);

    // Handshake table, PRBS31 from zero state.
    for (int i = 0; i < 10; i++) begin
      gen_en = vecs[i].gen_en;
      rand_ready = vecs[i].rand_ready;
      cyc();
      check($sformatf("vec%0d_valid", i), {63'd0, rand_valid}, {63'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_count", i), {32'd0, gen_count}, {32'd0, vecs[i].exp_count});
      check($sformatf("vec%0d_rand", i), rand_word, w3[vecs[i].exp_count]);
      if (i == 0) check("prbs31_first_low32", {32'd0, rand_word[31:0]}, 64'h8FFF_FFFF);
    end

    // PRBS7 first byte and 127-bit period.
    mode = 2'd0;
    do_reset();
    gen_en = 1'b1; rand_ready = 1'b1;
    cyc(); stream[63:0] = rand_word;
    check("prbs7_first_byte", {56'd0, rand_word[7:0]}, 64'h0000_0000_0000_00BF);
    cyc(); stream[127:64] = rand_word;
    cyc(); stream[191:128] = rand_word;
    gen_en = 1'b0;
    period_bad = 0;
    for (int i = 0; i < 65; i++) if (stream[i] !== stream[i+127]) period_bad++;
    check("prbs7_period127", 64'(period_bad), 64'd0);

    // Backpressure: word held for 5 cycles, then next golden word.
    mode = 2'd3;
    do_reset();
    gen_en = 1'b1; rand_ready = 1'b1;
    cyc();
    rand_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("stall%0d_rand", i), rand_word, w3[1]);
      check($sformatf("stall%0d_count", i), {32'd0, gen_count}, 64'd1);
    end
    rand_ready = 1'b1;
    cyc();
    check("stall_release_rand", rand_word, w3[2]);
    check("stall_release_count", {32'd0, gen_count}, 64'd2);
    gen_en = 1'b0;
    cyc();

    // Loopback: PRBS23 from a loaded seed, 1000 clean words then one flipped bit.
    mode = 2'd2; seed = 31'h0012_3456;
    load = 1'b1; cyc(); load = 1'b0;
    exp_first = mword(2'd2, 31'h0012_3456, tmp_s);
    gen_en = 1'b1; rand_ready = 1'b1;
    for (int k = 0; k < 1020; k++) begin
      cyc();
      if (k == 0) check("loop_first_word", rand_word, exp_first);
      if (k == 999) begin
        check("loop1000_err", {63'd0, err}, 64'd0);
        check("loop1000_err_count", {32'd0, err_count}, 64'd0);
        check("loop1000_gen_count", {32'd0, gen_count}, 64'd1000);
      end
      if (k == 1009) check("flip_err_not_yet", {63'd0, err}, 64'd0);
      if (k == 1010) check("flip_err_next_cycle", {63'd0, err}, 64'd1);
      chk_valid = rand_valid;
      chk_data  = rand_word ^ ((k == 1009) ? 64'd1 : 64'd0);
    end
    chk_valid = 1'b0; gen_en = 1'b0;
    cyc(); cyc();
    check("flip_err", {63'd0, err}, 64'd1);
    check("flip_err_count", {32'd0, err_count}, 64'd1);

    // Lockup seed under PRBS31 loads as zero; first word equals post-reset word.
    mode = 2'd3; seed = 31'h7FFF_FFFF;
    load = 1'b1; cyc(); load = 1'b0;
    check("load_clears_err", {63'd0, err}, 64'd0);
    check("load_clears_err_count", {32'd0, err_count}, 64'd0);
    gen_en = 1'b1; rand_ready = 1'b0;
    cyc();
    check("lockup_seed_word", rand_word, w3[1]);
    // Load while a word is pending, with gen_en still high.
    held = rand_word;
    load = 1'b1; cyc(); load = 1'b0;
    check("load_pending_valid", {63'd0, rand_valid}, 64'd0);
    check("load_pending_count", {32'd0, gen_count}, 64'd0);
    check("load_pending_rand", rand_word, 64'd0);
    gen_en = 1'b0;

    // PRBS7 lockup: active bits [6:0] all ones -> zero state.
    mode = 2'd0; seed = 31'h0000_007F;
    load = 1'b1; cyc(); load = 1'b0;
    gen_en = 1'b1; rand_ready = 1'b1;
    cyc(); gen_en = 1'b0;
    check("prbs7_lockup_byte", {56'd0, rand_word[7:0]}, 64'h0000_0000_0000_00BF);

    // Reset beats load.
    mode = 2'd3; seed = 31'h0000_0005;
    rst = 1'b1; load = 1'b1; cyc(); rst = 1'b0; load = 1'b0;
    gen_en = 1'b1; rand_ready = 1'b1;
    cyc(); gen_en = 1'b0;
    check("rst_over_load_word", rand_word, w3[1]);

    // Saturation of err_count.
    seed = 31'd0;
    load = 1'b1; cyc(); load = 1'b0;
    force dut.err_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.err_count_q;
    chk_valid = 1'b1; chk_data = 64'd0;
    cyc();
    chk_valid = 1'b0;
    cyc();
    check("sat_err_count", {32'd0, err_count}, 64'h0000_0000_FFFF_FFFF);
    check("sat_err", {63'd0, err}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
